// File: rtl/sprite_pkg.sv
// sprite_pkg: shared definitions for the sprite pixel path.
//   facing_t      : facing codes carried in the top bits of the ROM address
//   TRANSPARENT   : ROM word that marks a see-through sprite pixel
//   palette       : RRGGBB constants used by the sprite artwork
//   anim_state_t  : per-sprite hop-animation state
package sprite_pkg;

   typedef enum logic [1:0] {
      FACE_UP    = 2'd0,
      FACE_DOWN  = 2'd1,
      FACE_LEFT  = 2'd2,
      FACE_RIGHT = 2'd3
   } facing_t;

   localparam logic [5:0] TRANSPARENT = 6'b000000;

   localparam logic [5:0] LIGHT_GREEN = 6'b001100;
   localparam logic [5:0] DARK_GREEN  = 6'b000100;
   localparam logic [5:0] ORANGE      = 6'b111000;
   localparam logic [5:0] EYE_WHITE   = 6'b111111;
   localparam logic [5:0] PUPIL       = 6'b000001;

   typedef enum logic {
      IDLE = 1'b0,
      HOP  = 1'b1
   } anim_state_t;

endpackage

// File: rtl/sprite_anim_fsm.sv
// sprite_anim_fsm: hop-animation sequencer for one sprite.
// Ports:
//   clk        in   pixel clock
//   rst_n      in   synchronous active-low reset
//   frame_tick in   one-cycle pulse per video frame
//   en         in   sprite enable; low forces IDLE / frame 0 on the next edge
//   hop_start  in   one-cycle hop request, honoured only in IDLE
//   frame      out  current animation frame (0 in IDLE, 1..N_FRAMES-1 in HOP)
//   busy       out  high while in HOP (this is the exposed FSM state)
module sprite_anim_fsm
   import sprite_pkg::*;
#(
   parameter int N_FRAMES    = 4,
   parameter int FRAME_TICKS = 3,
   parameter int FRAME_W     = $clog2(N_FRAMES)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               frame_tick,
   input  logic               en,
   input  logic               hop_start,
   output logic [FRAME_W-1:0] frame,
   output logic               busy
);

   localparam int TICK_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
   localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(FRAME_TICKS - 1);
   localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(N_FRAMES - 1);

   anim_state_t        state_q, state_d;
   logic [FRAME_W-1:0] frame_q, frame_d;
   logic [TICK_W-1:0]  tick_q,  tick_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         frame_q <= '0;
         tick_q  <= '0;
      end else begin
         state_q <= state_d;
         frame_q <= frame_d;
         tick_q  <= tick_d;
      end
   end

   always_comb begin
      state_d = state_q;
      frame_d = frame_q;
      tick_d  = tick_q;
      if (!en) begin
         state_d = IDLE;
         frame_d = '0;
         tick_d  = '0;
      end else begin
         case (state_q)
            IDLE: begin
               // A tick arriving with the start is deliberately not counted.
               if (hop_start) begin
                  state_d = HOP;
                  frame_d = FRAME_W'(1);
                  tick_d  = '0;
               end
            end
            HOP: begin
               // hop_start is ignored here: no retrigger mid-hop.
               if (frame_tick) begin
                  if (tick_q == TICK_LAST) begin
                     tick_d = '0;
                     if (frame_q == FRAME_LAST) begin
                        state_d = IDLE;
                        frame_d = '0;
                     end else begin
                        frame_d = frame_q + FRAME_W'(1);
                     end
                  end else begin
                     tick_d = tick_q + TICK_W'(1);
                  end
               end
            end
            default: begin
               state_d = IDLE;
               frame_d = '0;
               tick_d  = '0;
            end
         endcase
      end
   end

   assign frame = frame_q;
   assign busy  = (state_q == HOP);

endmodule

// File: rtl/sprite_anim_gen.sv
// sprite_anim_gen: multi-sprite pixel generator.
// Ports:
//   clk, rst_n         pixel clock, synchronous active-low reset
//   frame_tick         one pulse per video frame, steps hop animations
//   col_pos, row_pos   raster position (10 bits each)
//   spr_x, spr_y       per-sprite top-left corner
//   spr_facing         per-sprite facing code (up/down/left/right)
//   spr_en             per-sprite enable
//   hop_start          per-sprite one-cycle hop request
//   hop_busy           per-sprite "in HOP" flag
//   rom_addr           {facing, frame, local_y, local_x} of the winning sprite
//   rom_data           sprite ROM word, one clock after rom_addr
//   pixel_color        sprite colour, 0 when pixel_valid is low
//   pixel_valid        an opaque sprite pixel is present
// Output semantics: pixel_valid/pixel_color form a valid-only stream with no
// back-pressure; one result per clock, two clocks after col_pos/row_pos. The
// display mux must accept every cycle and delays its background to match.
module sprite_anim_gen
   import sprite_pkg::*;
#(
   parameter  int N_SPRITES   = 4,
   parameter  int SPRITE_BITS = 5,
   parameter  int COLOR_W     = 6,
   parameter  int N_FRAMES    = 4,
   parameter  int FRAME_TICKS = 3,
   localparam int FRAME_W     = $clog2(N_FRAMES),
   localparam int ADDR_W      = 2 + FRAME_W + 2 * SPRITE_BITS
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       frame_tick,
   input  logic [9:0]                 col_pos,
   input  logic [9:0]                 row_pos,
   input  logic [N_SPRITES-1:0][9:0]  spr_x,
   input  logic [N_SPRITES-1:0][9:0]  spr_y,
   input  logic [N_SPRITES-1:0][1:0]  spr_facing,
   input  logic [N_SPRITES-1:0]       spr_en,
   input  logic [N_SPRITES-1:0]       hop_start,
   output logic [N_SPRITES-1:0]       hop_busy,
   output logic [ADDR_W-1:0]          rom_addr,
   input  logic [COLOR_W-1:0]         rom_data,
   output logic [COLOR_W-1:0]         pixel_color,
   output logic                       pixel_valid
);

   localparam int IDX_W = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1;
   localparam logic [10:0] SPR_SIZE = 11'(1 << SPRITE_BITS);

   logic [N_SPRITES-1:0][FRAME_W-1:0] frame_all;
   logic [N_SPRITES-1:0]              hit;

   // Per-sprite animation sequencers and bounding-box tests. Compares are
   // done at 11 bits so a sprite near column/row 1023 clips instead of
   // wrapping round to 0.
   for (genvar g = 0; g < N_SPRITES; g++) begin : g_spr
      logic [10:0] x_lo, y_lo, x_hi, y_hi, col_ext, row_ext;

      sprite_anim_fsm #(
         .N_FRAMES    (N_FRAMES),
         .FRAME_TICKS (FRAME_TICKS),
         .FRAME_W     (FRAME_W)
      ) u_fsm (
         .clk        (clk),
         .rst_n      (rst_n),
         .frame_tick (frame_tick),
         .en         (spr_en[g]),
         .hop_start  (hop_start[g]),
         .frame      (frame_all[g]),
         .busy       (hop_busy[g])
      );

      assign col_ext = {1'b0, col_pos};
      assign row_ext = {1'b0, row_pos};
      assign x_lo    = {1'b0, spr_x[g]};
      assign y_lo    = {1'b0, spr_y[g]};
      assign x_hi    = x_lo + SPR_SIZE;
      assign y_hi    = y_lo + SPR_SIZE;
      assign hit[g]  = spr_en[g] &&
                       (col_ext >= x_lo) && (col_ext < x_hi) &&
                       (row_ext >= y_lo) && (row_ext < y_hi);
   end

   // Priority encoder: scanning from the top down leaves the lowest-index
   // hit as the winner.
   logic [IDX_W-1:0] win_idx;
   logic             any_hit;

   always_comb begin
      win_idx = '0;
      any_hit = 1'b0;
      for (int i = N_SPRITES - 1; i >= 0; i--) begin
         if (hit[i]) begin
            win_idx = IDX_W'(i);
            any_hit = 1'b1;
         end
      end
   end

   logic [SPRITE_BITS-1:0] local_x, local_y;
   logic [ADDR_W-1:0]      addr_d;

   always_comb begin
      local_x = SPRITE_BITS'(col_pos - spr_x[win_idx]);
      local_y = SPRITE_BITS'(row_pos - spr_y[win_idx]);
      addr_d  = '0;
      if (any_hit) begin
         addr_d = {spr_facing[win_idx], frame_all[win_idx], local_y, local_x};
      end
   end

   // Stage 1: address to the ROM plus the hit flag that travels with it.
   logic hit_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hit_q    <= 1'b0;
         rom_addr <= '0;
      end else begin
         hit_q    <= any_hit;
         rom_addr <= addr_d;
      end
   end

   // Stage 2: a transparent winner pixel stays invisible; lower-priority
   // sprites underneath are never fetched, so they cannot show through.
   logic opaque;

   assign opaque = hit_q && (rom_data != COLOR_W'(TRANSPARENT));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pixel_valid <= 1'b0;
         pixel_color <= '0;
      end else begin
         pixel_valid <= opaque;
         pixel_color <= opaque ? rom_data : '0;
      end
   end

endmodule

// File: tb/tb_sprite_anim_gen.sv
module tb_sprite_anim_gen;
   import sprite_pkg::*;

   localparam int N_SPR  = 4;
   localparam int ADDR_W = 14;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                    rst_n;
   logic                    frame_tick;
   logic [9:0]              col_pos, row_pos;
   logic [N_SPR-1:0][9:0]   spr_x, spr_y;
   logic [N_SPR-1:0][1:0]   spr_facing;
   logic [N_SPR-1:0]        spr_en;
   logic [N_SPR-1:0]        hop_start;
   logic [N_SPR-1:0]        hop_busy;
   logic [ADDR_W-1:0]       rom_addr;
   logic [5:0]              rom_data;
   logic [5:0]              pixel_color;
   logic                    pixel_valid;

   sprite_anim_gen dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .frame_tick  (frame_tick),
      .col_pos     (col_pos),
      .row_pos     (row_pos),
      .spr_x       (spr_x),
      .spr_y       (spr_y),
      .spr_facing  (spr_facing),
      .spr_en      (spr_en),
      .hop_start   (hop_start),
      .hop_busy    (hop_busy),
      .rom_addr    (rom_addr),
      .rom_data    (rom_data),
      .pixel_color (pixel_color),
      .pixel_valid (pixel_valid)
   );

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_tick();
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
   endtask

   // Sprite 2 sits at (800,100) facing right, sprite 3 at (600,400) facing down.
   typedef struct {
      logic [9:0]  col, row, x0, y0, x1, y1;
      logic [1:0]  f0, f1;
      logic [3:0]  en;
      logic [5:0]  rom;
      logic [13:0] exp_addr;
      logic        exp_valid;
      logic [5:0]  exp_color;
   } vec_t;

   vec_t vecs[11];

   initial begin
      vecs[0]  = '{10'd105, 10'd210, 10'd100, 10'd200, 10'd0,  10'd0,  2'd3, 2'd0, 4'b0001, 6'b001100, 14'd12613, 1'b1, 6'b001100};
      vecs[1]  = '{10'd60,  10'd55,  10'd50,  10'd50,  10'd50, 10'd50, 2'd1, 2'd2, 4'b0011, 6'b000000, 14'd4266,  1'b0, 6'b000000};
      vecs[2]  = '{10'd60,  10'd55,  10'd50,  10'd50,  10'd50, 10'd50, 2'd1, 2'd2, 4'b0010, 6'b111000, 14'd8362,  1'b1, 6'b111000};
      vecs[3]  = '{10'd1023,10'd31,  10'd1010,10'd0,   10'd0,  10'd0,  2'd0, 2'd0, 4'b0001, 6'b000001, 14'd1005,  1'b1, 6'b000001};
      vecs[4]  = '{10'd0,   10'd0,   10'd1010,10'd0,   10'd0,  10'd0,  2'd0, 2'd0, 4'b0001, 6'b111111, 14'd0,     1'b0, 6'b000000};
      vecs[5]  = '{10'd131, 10'd231, 10'd100, 10'd200, 10'd0,  10'd0,  2'd2, 2'd0, 4'b0001, 6'b000100, 14'd9215,  1'b1, 6'b000100};
      vecs[6]  = '{10'd132, 10'd210, 10'd100, 10'd200, 10'd0,  10'd0,  2'd2, 2'd0, 4'b0001, 6'b111111, 14'd0,     1'b0, 6'b000000};
      vecs[7]  = '{10'd99,  10'd210, 10'd100, 10'd200, 10'd0,  10'd0,  2'd2, 2'd0, 4'b0001, 6'b111111, 14'd0,     1'b0, 6'b000000};
      vecs[8]  = '{10'd51,  10'd52,  10'd300, 10'd300, 10'd50, 10'd50, 2'd0, 2'd1, 4'b0011, 6'b011101, 14'd4161,  1'b1, 6'b011101};
      vecs[9]  = '{10'd610, 10'd420, 10'd0,   10'd0,   10'd0,  10'd0,  2'd0, 2'd0, 4'b1000, 6'b101010, 14'd4746,  1'b1, 6'b101010};
      vecs[10] = '{10'd105, 10'd232, 10'd100, 10'd200, 10'd0,  10'd0,  2'd3, 2'd0, 4'b0001, 6'b111111, 14'd0,     1'b0, 6'b000000};
   end

   // Expected frame after k counted ticks of a default hop (3 ticks/frame).
   function automatic int hop_frame(input int k);
      return (k < 9) ? 1 + k / 3 : 0;
   endfunction

   // ---------------- test sequence ----------------
   initial begin
      // Reset with every hop requested and a sprite under the raster.
      rst_n      = 1'b0;
      frame_tick = 1'b0;
      hop_start  = 4'b1111;
      spr_en     = 4'b1111;
      spr_x      = '{10'd600, 10'd800, 10'd0, 10'd100};
      spr_y      = '{10'd400, 10'd100, 10'd0, 10'd200};
      spr_facing = '{2'd1, 2'd3, 2'd0, 2'd3};
      col_pos    = 10'd105;
      row_pos    = 10'd210;
      rom_data   = 6'b111111;
      step();
      check("rst_addr",  32'(rom_addr),    32'd0);
      check("rst_valid", 32'(pixel_valid), 32'd0);
      check("rst_color", 32'(pixel_color), 32'd0);
      check("rst_busy",  32'(hop_busy),    32'd0);
      repeat (3) step();
      check("rst_busy_hold", 32'(hop_busy), 32'd0);
      check("rst_addr_hold", 32'(rom_addr), 32'd0);
      rst_n     = 1'b1;
      hop_start = 4'b0000;
      spr_en    = 4'b0000;
      step();

      // Table-driven hit / priority / transparency / clipping vectors.
      for (int v = 0; v < 11; v++) begin
         col_pos       = vecs[v].col;
         row_pos       = vecs[v].row;
         spr_x[0]      = vecs[v].x0;
         spr_y[0]      = vecs[v].y0;
         spr_x[1]      = vecs[v].x1;
         spr_y[1]      = vecs[v].y1;
         spr_facing[0] = vecs[v].f0;
         spr_facing[1] = vecs[v].f1;
         spr_en        = vecs[v].en;
         rom_data      = 6'b000000;
         step();
         check($sformatf("vec%0d_addr", v), 32'(rom_addr), 32'(vecs[v].exp_addr));
         rom_data = vecs[v].rom;
         step();
         check($sformatf("vec%0d_valid", v), 32'(pixel_valid), 32'(vecs[v].exp_valid));
         check($sformatf("vec%0d_color", v), 32'(pixel_color), 32'(vecs[v].exp_color));
      end

      // Hop sequence on sprite 2 at (800,100) facing right; frame seen in rom_addr[11:10].
      spr_en   = 4'b0100;
      col_pos  = 10'd800;
      row_pos  = 10'd100;
      rom_data = 6'b000000;
      step();
      hop_start = 4'b0100;
      step();
      hop_start = 4'b0000;
      check("hop_busy_rise", 32'(hop_busy), 32'b0100);
      step();
      check("hop_addr_f1", 32'(rom_addr), 32'd12288 | (32'd1 << 10));
      for (int k = 1; k <= 9; k++) begin
         if (k == 4) begin
            hop_start = 4'b0100;
            step();
            hop_start = 4'b0000;
         end
         pulse_tick();
         check($sformatf("hop_busy_t%0d", k), 32'(hop_busy[2]), (k < 9) ? 32'd1 : 32'd0);
         step();
         check($sformatf("hop_addr_t%0d", k), 32'(rom_addr), 32'd12288 | (32'(hop_frame(k)) << 10));
      end

      // hop_start coincident with frame_tick on sprite 0 at (100,200).
      spr_x[0]      = 10'd100;
      spr_y[0]      = 10'd200;
      spr_facing[0] = 2'd3;
      spr_en        = 4'b0001;
      col_pos       = 10'd100;
      row_pos       = 10'd200;
      step();
      hop_start  = 4'b0001;
      frame_tick = 1'b1;
      step();
      hop_start  = 4'b0000;
      frame_tick = 1'b0;
      check("coinc_busy", 32'(hop_busy), 32'b0001);
      step();
      check("coinc_f1", 32'(rom_addr), 32'd12288 | (32'd1 << 10));
      pulse_tick();
      pulse_tick();
      step();
      check("coinc_f1_after2", 32'(rom_addr), 32'd12288 | (32'd1 << 10));
      pulse_tick();
      step();
      check("coinc_f2_after3", 32'(rom_addr), 32'd12288 | (32'd2 << 10));

      // Enable dropped mid-hop aborts on the next edge.
      spr_en = 4'b0000;
      step();
      check("en_drop_busy", 32'(hop_busy), 32'd0);
      spr_en = 4'b0001;
      step();
      step();
      check("en_drop_frame0", 32'(rom_addr), 32'd12288);

      // Facing change mid-hop: new facing on the next address, same frame.
      hop_start = 4'b0001;
      step();
      hop_start     = 4'b0000;
      spr_facing[0] = 2'd0;
      step();
      check("facing_change", 32'(rom_addr), 32'd1 << 10);

      // Reset mid-hop aborts the hop.
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check("rst_midhop_busy", 32'(hop_busy), 32'd0);
      check("rst_midhop_addr", 32'(rom_addr), 32'd0);
      step();
      check("post_rst_frame0", 32'(rom_addr), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sprite_anim_gen.md
# sprite_anim_gen

Parametrised multi-sprite pixel generator for the Frogger video path. Tests the current raster position against up to N_SPRITES bounding boxes, builds a sprite-ROM address from the highest-priority hit's facing, animation frame and local pixel offset, and drives a registered pixel colour with a transparency-aware valid flag to the display mux. Each sprite has its own hop-animation state machine, stepped by a per-video-frame tick.

## Interface
Parameters:
- N_SPRITES, 4, number of sprite channels; index 0 has highest priority.
- SPRITE_BITS, 5, log2 of sprite edge length (5 gives 32x32).
- COLOR_W, 6, colour width (RRGGBB).
- N_FRAMES, 4, animation frames per facing; power of two, at least 2.
- FRAME_TICKS, 3, frame_tick pulses per animation frame, at least 1.
- FRAME_W, derived, log2(N_FRAMES).
- ADDR_W, derived, 2 + FRAME_W + 2*SPRITE_BITS.

Ports:
- clk, in, 1, pixel clock.
- rst_n, in, 1, synchronous active-low reset.
- frame_tick, in, 1, one-cycle pulse once per video frame.
- col_pos, in, 10, raster column.
- row_pos, in, 10, raster row.
- spr_x, in, N_SPRITES x 10, sprite top-left column.
- spr_y, in, N_SPRITES x 10, sprite top-left row.
- spr_facing, in, N_SPRITES x 2, facing code: 0 up, 1 down, 2 left, 3 right.
- spr_en, in, N_SPRITES, sprite enable.
- hop_start, in, N_SPRITES, one-cycle hop request per sprite.
- hop_busy, out, N_SPRITES, sprite is in HOP.
- rom_addr, out, ADDR_W, address to the synchronous sprite ROM, formed as {facing, frame, local_y, local_x}.
- rom_data, in, COLOR_W, ROM read data, valid one clock after rom_addr.
- pixel_color, out, COLOR_W, sprite colour; 0 when pixel_valid is low.
- pixel_valid, out, 1, an opaque sprite pixel is present.

## Operation
- **Hit test:** sprite i hits when spr_en[i] is high, spr_x ≤ col_pos < spr_x + 2^SPRITE_BITS, and the same holds for rows. Sums are 11 bits wide, so sprites near 1023 clip and never wrap.
- **Priority:** the lowest-index hit wins. Only the winner's ROM word is read. A transparent winner pixel does not reveal lower-priority sprites.
- **Local offset:** col_pos − spr_x, truncated to SPRITE_BITS. Rows use the same rule.
- **Transparency:** a rom_data value equal to TRANSPARENT (all zeros) gives pixel_valid 0 and pixel_color 0.
- **Per-sprite FSM states:**
  - IDLE: frame 0, hop_busy 0.
  - IDLE → HOP on hop_start[i] while spr_en[i] is high. On that edge frame becomes 1 and tick_cnt becomes 0.
  - In HOP, each frame_tick increments tick_cnt. When tick_cnt = FRAME_TICKS−1 and frame_tick is high, tick_cnt becomes 0 and frame increments.
  - From frame N_FRAMES−1, that same event returns the sprite to IDLE with frame 0.
- **Boundary cases:**
  - hop_start during HOP is ignored; there is no retrigger.
  - hop_start together with frame_tick in IDLE: the start is taken and the tick is not counted.
  - spr_en[i] low forces IDLE, frame 0 and tick_cnt 0 on the next edge, whatever the current state.
  - A facing change mid-hop takes effect on the next rom_addr and does not alter the frame sequence.
- **Reset** (rst_n low at a clk edge):
  - All FSMs go to IDLE with frame 0 and tick_cnt 0.
  - hop_busy, rom_addr, pixel_color and pixel_valid are all 0.
  - The hit pipeline flags are cleared.
  - Reset mid-hop aborts the hop.

## Timing
- Stage 1 (edge t+1): registered hit flag and rom_addr from the col_pos/row_pos presented at cycle t.
- Stage 2 (edge t+2): rom_data is valid. pixel_color and pixel_valid are registered from rom_data and the delayed hit flag.
- Total latency from col/row to pixel outputs is 2 clocks at full throughput, one pixel per clock. The display mux delays its background by the same amount.
- hop_busy rises on the edge after hop_start.
- A hop lasts (N_FRAMES−1) × FRAME_TICKS frame_ticks. hop_busy falls on the edge that samples the final counted tick.
- Animation state changes apply to rom_addr on the following clock. A frame change lands mid-frame only if frame_tick is not aligned to vertical blank, which is the caller's responsibility.

## Structure
- Shared package `sprite_pkg` holds:
  - the facing enum (FACE_UP=0, FACE_DOWN=1, FACE_LEFT=2, FACE_RIGHT=3);
  - the TRANSPARENT constant;
  - the palette constants LIGHT_GREEN, DARK_GREEN, ORANGE, EYE_WHITE and PUPIL;
  - the anim_state_t enum {IDLE, HOP}.
- Sub-module `sprite_anim_fsm`, instantiated N_SPRITES times, holds one sprite's state, frame and tick_cnt, with ports clk, rst_n, frame_tick, en, hop_start, frame and busy.
- Hit test, priority encoder and output pipeline live in the top level. The ROM is external.

## Test plan
- **Reset:** hold rst_n low 4 clocks with hop_start asserted → all outputs 0 and hop_busy 0 after the first edge.
- **Single hit:** sprite 0 at (100,200), facing 3, IDLE; drive col 105, row 210 → rom_addr = {2'd3, 2'd0, 5'd10, 5'd5} at t+1. With rom_data 6'b001100 returned, pixel_valid 1 and pixel_color 6'b001100 at t+2.
- **Priority and transparency:**
  - Sprites 0 and 1 both at (50,50); sprite 0 ROM returns 0 → pixel_valid 0.
  - Disable sprite 0 → the address uses sprite 1's facing.
- **Hop sequence** (defaults): pulse hop_start[2], then 9 frame_ticks → frame goes 1,1,1,2,2,2,3,3,3 then IDLE/0, and hop_busy falls with the 9th tick. A second hop_start at tick 4 has no effect.
- **Edge cases:**
  - Sprite at x=1010 with col 1023 → hit. col 0 → no hit, since there is no wrap.
  - spr_en dropped mid-hop → IDLE next edge.
  - hop_start coincident with frame_tick → frame 1, tick_cnt 0.
